adder_share_arbiter: RTL and testbench

//   Shares one 64-bit ripple adder datapath among N_REQ requesters.

---
 rtl/adder_pkg.sv | 10 +
 rtl/rr_pick.sv | 20 ++
 rtl/adder_share_arbiter.sv | 81 ++++++++
 tb/tb_adder_share_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and default sizing for the shared-adder arbiter
package adder_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_N_REQ = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or after ptr wins
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   // scan downward so the lowest offset from ptr is the final assignment
   always_comb begin
      idx = '0;
      any = |req;
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
      onehot = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one ripple adder among N_REQ requesters,
// one operation in flight, result returned tagged over valid/ready
module adder_share_arbiter
   import adder_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_flat,
   input  logic [N_REQ*WIDTH-1:0] b_flat,
   output logic [N_REQ-1:0]       gnt,
   output logic                   res_valid,
   output logic [WIDTH-1:0]       res_data,
   output logic                   res_carry,
   output logic [ID_W-1:0]        res_id,
   input  logic                   res_ready
);
   state_t            state, state_nx;
   logic [ID_W-1:0]   rr_ptr, id_q, win_idx;
   logic [N_REQ-1:0]  win_oh;
   logic              any, take;
   logic [WIDTH-1:0]  a_q, b_q, sum;
   logic [WIDTH:0]    c;

   rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
      .req(req), .ptr(rr_ptr), .onehot(win_oh), .idx(win_idx), .any(any)
   );

   assign take = (state == ST_IDLE) && any;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = (state == ST_IDLE) ? (any ? ST_ADD : ST_IDLE) :
                 (state == ST_ADD)  ? ST_HOLD :
                 (state == ST_HOLD && !res_ready) ? ST_HOLD : ST_IDLE;
   end

   always_comb begin
      c = '0;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a_q[i] ^ b_q[i] ^ c[i];
         c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rr_ptr    <= '0;
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         gnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_id    <= '0;
      end else begin
         gnt <= take ? win_oh : '0;
         if (take) begin
            a_q    <= a_flat[win_idx*WIDTH +: WIDTH];
            b_q    <= b_flat[win_idx*WIDTH +: WIDTH];
            id_q   <= win_idx;
            rr_ptr <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (state == ST_ADD) begin
            res_data  <= sum;
            res_carry <= c[WIDTH];
            res_id    <= id_q;
            res_valid <= 1'b1;
         end
         if (state == ST_HOLD && res_ready) res_valid <= 1'b0;
      end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed + random checks of the shared adder against a
// transaction-level model (grant/compute/present phases, 65-bit arithmetic sum)
module tb_adder_share_arbiter;
   localparam int N = 4;
   localparam int W = 64;
   localparam logic [W-1:0] ONES = '1;
   localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] a_flat = '0, b_flat = '0;
   logic [N-1:0]   gnt;
   logic           res_valid, res_carry, res_ready = 1'b1;
   logic [W-1:0]   res_data;
   logic [1:0]     res_id;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit started = 0;

   adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .gnt(gnt), .res_valid(res_valid), .res_data(res_data),
      .res_carry(res_carry), .res_id(res_id), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   // model: phase 0 may grant, phase 1 computes, phase 2 presents until accepted
   int           m_phase = 0, m_ptr = 0, m_id = 0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic [N-1:0] e_gnt = '0;
   logic         e_valid = 0, e_carry = 0;
   logic [W-1:0] e_data = '0;
   logic [1:0]   e_id = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_ptr <= 0; m_id <= 0; m_a <= '0; m_b <= '0;
         e_gnt <= '0; e_valid <= 0; e_carry <= 0; e_data <= '0; e_id <= '0;
      end else if (m_phase == 0) begin
         e_gnt <= '0;
         if (req != 0) begin
            e_gnt   <= N'(1) << pick(req, m_ptr);
            m_a     <= a_flat[pick(req, m_ptr)*W +: W];
            m_b     <= b_flat[pick(req, m_ptr)*W +: W];
            m_id    <= pick(req, m_ptr);
            m_ptr   <= (pick(req, m_ptr) + 1) % N;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         e_gnt <= '0;
         {e_carry, e_data} <= {1'b0, m_a} + {1'b0, m_b};
         e_id    <= 2'(m_id);
         e_valid <= 1;
         m_phase <= 2;
      end else if (res_ready) begin
         e_valid <= 0;
         m_phase <= 0;
      end
   end

   int g_id[$], g_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (started) begin
      chk("gnt", W'(gnt), W'(e_gnt));
      chk("res_valid", W'(res_valid), W'(e_valid));
      chk("res_data", res_data, e_data);
      chk("res_carry", W'(res_carry), W'(e_carry));
      chk("res_id", W'(res_id), W'(e_id));
      chk("gnt_onehot0", W'($onehot0(gnt)), 64'd1);
      chk("gnt_and_valid", W'(gnt != 0 && res_valid), 64'd0);
      for (int i = 0; i < N; i++) if (gnt[i]) begin
         g_id.push_back(i);
         g_cyc.push_back(cyc);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_flat[i*W +: W] = a;
      b_flat[i*W +: W] = b;
   endtask

   task automatic do_reset();
      req = '0;
      #1 rst = 1'b1;
      step(2);
      rst = 1'b0;
      started = 1;
      step(1);
   endtask

   logic [W-1:0] held;

   initial begin
      do_reset();
      // two plain adds, the second left unaccepted to test async reset mid-cycle
      set_op(0, 64'd1, 64'd2);
      req = 4'b0001;
      step();
      chk("t2_gnt", W'(gnt), 64'h1);
      req = '0;
      step();
      chk("t2_valid", W'(res_valid), 64'd1);
      chk("t2_data", res_data, 64'd3);
      chk("t2_carry", W'(res_carry), 64'd0);
      chk("t2_id", W'(res_id), 64'd0);
      step();
      res_ready = 0;
      set_op(1, 64'd5, 64'd7);
      req = 4'b0010;
      step();
      req = '0;
      step();
      chk("t1_pre_valid", W'(res_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("t1_valid", W'(res_valid), 64'd0);
      chk("t1_gnt", W'(gnt), 64'd0);
      chk("t1_data", res_data, 64'd0);
      chk("t1_id", W'(res_id), 64'd0);
      step();
      rst = 1'b0;
      res_ready = 1;
      step();

      set_op(2, ONES, 64'd1);
      req = 4'b0100;
      step();
      chk("t3_gnt", W'(gnt), 64'h4);
      req = '0;
      step();
      chk("t3_data", res_data, 64'd0);
      chk("t3_carry", W'(res_carry), 64'd1);
      chk("t3_id", W'(res_id), 64'd2);
      step();
      set_op(3, MSB, MSB);
      req = 4'b1000;
      step();
      req = '0;
      step();
      chk("t3b_data", res_data, 64'd0);
      chk("t3b_carry", W'(res_carry), 64'd1);
      step();

      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 64'(i * 16), 64'(i + 1));
      g_id.delete();
      g_cyc.delete();
      req = 4'b1111;
      step(15);
      req = '0;
      step(3);
      chk("t4_count", W'(g_id.size() >= 5), 64'd1);
      if (g_id.size() >= 5)
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_order%0d", k), W'(g_id[k]), W'(k % N));
            if (k > 0) chk($sformatf("t4_gap%0d", k), W'(g_cyc[k] - g_cyc[k-1]), 64'd3);
         end

      do_reset();
      req = 4'b0010;
      step();
      req = '0;
      step(2);
      req = 4'b0011;
      step();
      chk("t4_ptr2_gnt", W'(gnt), 64'h1);
      req = '0;
      step(3);

      do_reset();
      res_ready = 0;
      req = 4'b1111;
      step(2);
      held = res_data;
      for (int k = 0; k < 5; k++) begin
         chk("t5_gnt", W'(gnt), 64'd0);
         chk("t5_valid", W'(res_valid), 64'd1);
         chk("t5_data", res_data, held);
         step();
      end
      res_ready = 1;
      step();
      chk("t5_consumed", W'(res_valid), 64'd0);
      step();
      chk("t5_next_gnt", W'(gnt), 64'h2);
      req = '0;
      step(3);

      do_reset();
      req = 4'b0100;
      step();
      chk("t6_gnt", W'(gnt), 64'h4);
      rst = 1'b1;
      req = '0;
      for (int k = 0; k < 3; k++) begin
         chk("t6_valid_rst", W'(res_valid), 64'd0);
         step();
      end
      rst = 1'b0;
      step();
      chk("t6_valid_after", W'(res_valid), 64'd0);
      req = 4'b0100;
      step();
      chk("t6_regnt", W'(gnt), 64'h4);
      req = '0;
      step(3);

      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++)
            case ($urandom_range(0, 7))
               0: set_op(i, ONES, 64'($urandom_range(0, 3)));
               1: set_op(i, MSB, MSB);
               default: set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
            endcase
         req = N'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req = '0;
      res_ready = 1;
      step(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
